// File: rtl/io_block_pad.sv
// rtl/io_block_pad.sv - configurable I/O tile linking pins to single/double/global routing tracks
//
// Purpose: connects EXTIN input pins and EXTOUT output pins to three tristate
// routing bundles. One configuration bit in c enables each pin/track crossing.
// The datapath is combinational; clk only feeds the flop that gates all fabric
// drivers and the output pins.
//
// Ports:
//   clk             - clock, used only by the active flop
//   rst_n           - synchronous active-low reset; releases every driver
//   single          - WS single-length tracks (inout)
//   double          - WD double-length tracks (inout)
//   global_trk      - WG global tracks (inout)
//   external_input  - pin values driven into the fabric
//   external_output - pin values sampled from the fabric
//   c               - flat configuration, W=WS+WD+WG bits per pin; inputs first,
//                     then outputs; within a field: single, double, global
module io_block_pad #(
  parameter int WS     = 7,
  parameter int WD     = 6,
  parameter int WG     = 3,
  parameter int EXTIN  = 5,
  parameter int EXTOUT = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  inout  wire  [WS-1:0]                             single,
  inout  wire  [WD-1:0]                             double,
  inout  wire  [WG-1:0]                             global_trk,
  input  logic [EXTIN-1:0]                          external_input,
  output logic [EXTOUT-1:0]                         external_output,
  input  logic [(EXTIN+EXTOUT)*(WS+WD+WG)-1:0]      c
);

  localparam int W = WS + WD + WG;

  logic         r_active;
  logic [W-1:0] w_drv_en;
  logic [W-1:0] w_drv_val;
  logic [W-1:0] w_trk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // Scan inputs from highest to lowest index so the lowest-indexed selecting
  // input is the last writer and wins; the others never reach the track.
  always_comb begin
    w_drv_en  = '0;
    w_drv_val = '0;
    for (int t = 0; t < W; t++) begin
      for (int i = EXTIN - 1; i >= 0; i--) begin
        if (c[i*W + t]) begin
          w_drv_en[t]  = 1'b1;
          w_drv_val[t] = external_input[i];
        end
      end
    end
    if (!r_active) begin
      w_drv_en = '0;
    end
  end

  for (genvar t = 0; t < WS; t++) begin : g_single
    assign single[t] = w_drv_en[t] ? w_drv_val[t] : 1'bz;
  end

  for (genvar t = 0; t < WD; t++) begin : g_double
    assign double[t] = w_drv_en[WS + t] ? w_drv_val[WS + t] : 1'bz;
  end

  for (genvar t = 0; t < WG; t++) begin : g_global
    assign global_trk[t] = w_drv_en[WS + WD + t] ? w_drv_val[WS + WD + t] : 1'bz;
  end

  // Resolved track values, laid out the same way as a configuration field.
  assign w_trk = {global_trk, double, single};

  always_comb begin
    external_output = '0;
    for (int k = 0; k < EXTOUT; k++) begin
      external_output[k] = r_active & (|(w_trk & c[(EXTIN + k)*W +: W]));
    end
  end

endmodule

// File: tb/tb_io_block_pad.sv
// tb/tb_io_block_pad.sv - self-checking bench for io_block_pad
module tb_io_block_pad;

  localparam int WS     = 7;
  localparam int WD     = 6;
  localparam int WG     = 3;
  localparam int EXTIN  = 5;
  localparam int EXTOUT = 2;
  localparam int W      = WS + WD + WG;
  localparam int CW     = (EXTIN + EXTOUT) * W;

  logic              clk;
  logic              rst_n;
  logic [EXTIN-1:0]  ext_in;
  logic [EXTOUT-1:0] ext_out;
  logic [CW-1:0]     cfg;
  logic              tb_drv;
  logic [W-1:0]      tb_val;
  logic              m_active;

  tri0 [WS-1:0] single;
  tri0 [WD-1:0] double;
  tri0 [WG-1:0] global_trk;

  assign single     = tb_drv ? tb_val[WS-1:0]       : {WS{1'bz}};
  assign double     = tb_drv ? tb_val[WS +: WD]     : {WD{1'bz}};
  assign global_trk = tb_drv ? tb_val[WS+WD +: WG]  : {WG{1'bz}};

  wire [W-1:0] trk = {global_trk, double, single};

  int checks = 0;
  int errors = 0;

  io_block_pad #(
    .WS(WS), .WD(WD), .WG(WG), .EXTIN(EXTIN), .EXTOUT(EXTOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .single          (single),
    .double          (double),
    .global_trk      (global_trk),
    .external_input  (ext_in),
    .external_output (ext_out),
    .c               (cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected track values: first selecting input by index, else the bench
  // driver, else the pull-down.
  function automatic logic [W-1:0] model_trk();
    logic [W-1:0] v;
    for (int t = 0; t < W; t++) begin
      int hit;
      hit  = -1;
      for (int i = 0; i < EXTIN; i++) begin
        if (hit < 0 && m_active && cfg[i*W + t]) hit = i;
      end
      if (hit >= 0)    v[t] = ext_in[hit];
      else if (tb_drv) v[t] = tb_val[t];
      else             v[t] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [EXTOUT-1:0] model_out();
    logic [W-1:0]      tv;
    logic [EXTOUT-1:0] o;
    tv = model_trk();
    for (int k = 0; k < EXTOUT; k++) begin
      o[k] = 1'b0;
      for (int t = 0; t < W; t++) begin
        if (m_active && cfg[(EXTIN + k)*W + t] && tv[t]) o[k] = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #2;
    check({tag, "_trk"}, 32'(trk), 32'(model_trk()));
    check({tag, "_out"}, 32'(ext_out), 32'(model_out()));
  endtask

  initial begin
    logic [W-1:0] tmp;
    rst_n    = 1'b0;
    cfg      = '1;
    ext_in   = 5'b11111;
    tb_drv   = 1'b0;
    tb_val   = '0;
    m_active = 1'b0;

    // Reset holds every driver released regardless of configuration.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    check("reset_trk", 32'(trk), 32'h0);
    check("reset_out", 32'(ext_out), 32'h0);

    // Leave reset with an empty configuration.
    cfg   = '0;
    rst_n = 1'b1;
    @(posedge clk);
    m_active = 1'b1;
    @(negedge clk);

    // Input 2 onto single[3], then toggle the pin without a clock edge.
    ext_in = 5'b00100;
    cfg[2*W + 3] = 1'b1;
    #2;
    check("in_single_set", 32'(trk), 32'h0008);
    ext_in[2] = 1'b0;
    #1;
    check("in_single_clr", 32'(trk), 32'h0000);
    check_all("in_single_model");

    // Random single/double/global selection for every input.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      cfg    = '0;
      ext_in = EXTIN'($urandom);
      for (int i = 0; i < EXTIN; i++) begin
        cfg[i*W + $urandom_range(WS-1)]         = 1'b1;
        cfg[i*W + WS + $urandom_range(WD-1)]    = 1'b1;
        cfg[i*W + WS + WD + $urandom_range(WG-1)] = 1'b1;
      end
      check_all("in_sweep");
    end

    // Output path: bench drives all tracks, outputs sample selected ones.
    tb_drv = 1'b1;
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      cfg    = '0;
      tb_val = W'($urandom);
      for (int k = 0; k < EXTOUT; k++) begin
        int j;
        case (v % 3)
          0:       j = $urandom_range(WS-1);
          1:       j = WS + $urandom_range(WD-1);
          default: j = WS + WD + $urandom_range(WG-1);
        endcase
        cfg[(EXTIN + k)*W + j] = 1'b1;
        #1;
        check("out_single_bit", 32'(ext_out[k]), 32'(tb_val[j]));
      end
      check_all("out_model");
    end

    // Random multi-bit output fields exercise the OR reduction.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      cfg    = '0;
      tb_val = W'($urandom);
      tmp    = W'($urandom);
      cfg[EXTIN*W +: W]       = tmp;
      cfg[(EXTIN + 1)*W +: W] = ~tmp;
      check_all("out_or");
    end

    // No output bit set gives 0 even with every track high.
    @(negedge clk);
    cfg    = '0;
    tb_val = '1;
    #2;
    check("out_none", 32'(ext_out), 32'h0);
    tb_drv = 1'b0;

    // Inputs 1 and 3 both select global[0]; input 1 wins.
    @(negedge clk);
    cfg    = '0;
    ext_in = 5'b01000;
    cfg[1*W + WS + WD] = 1'b1;
    cfg[3*W + WS + WD] = 1'b1;
    #2;
    check("prio_global0", 32'(global_trk[0]), 32'h0);
    check_all("prio_model");
    ext_in = 5'b00010;
    #1;
    check("prio_global0_hi", 32'(global_trk[0]), 32'h1);

    // Loopback: input 0 -> double[2] -> output 1, no clock latency.
    @(negedge clk);
    cfg    = '0;
    ext_in = 5'b00000;
    cfg[0*W + WS + 2]            = 1'b1;
    cfg[(EXTIN + 1)*W + WS + 2]  = 1'b1;
    #1;
    check("loop_lo", 32'(ext_out[1]), 32'h0);
    ext_in[0] = 1'b1;
    #1;
    check("loop_hi", 32'(ext_out[1]), 32'h1);
    check_all("loop_model");

    // Mid-operation reset takes effect only at the clock edge.
    rst_n = 1'b0;
    #1;
    check("rst_pre_edge", 32'(ext_out[1]), 32'h1);
    @(posedge clk);
    m_active = 1'b0;
    @(negedge clk);
    #2;
    check("rst_mid_trk", 32'(trk), 32'h0);
    check("rst_mid_out", 32'(ext_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
